// File: rtl/rbsp_bit_writer_pkg.sv
// Shared definitions for the RBSP bit writer: the emulation-prevention byte value,
// the writer state encoding and the largest accepted field length.
package rbsp_bit_writer_pkg;

  localparam logic [7:0]  EPB_BYTE      = 8'h03;
  localparam int unsigned MAX_FIELD_LEN = 32;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/rbsp_epb_inserter.sv
// Emulation-prevention stage and output register of the RBSP bit writer.
// Tracks the run of zero bytes already emitted; a candidate byte <= 0x03 after two
// zeros is preceded by an inserted 0x03 while the candidate waits in a hold register.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ena               global enable, 0 freezes all state
//   in_valid/in_byte  byte extracted from the accumulator this cycle
//   in_last           extracted byte is the final byte of the RBSP
//   clear_run         clears the zero-run tracker (end of RBSP)
//   can_take          stage can accept an extracted byte this cycle
//   byte_*            downstream byte stream with valid/ready handshake
//   xfer              a byte transfers downstream this cycle
module rbsp_epb_inserter
  import rbsp_bit_writer_pkg::*;
#(
  parameter bit EPB_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       in_valid,
  input  logic [7:0] in_byte,
  input  logic       in_last,
  input  logic       clear_run,
  output logic       can_take,
  input  logic       byte_ready_in,
  output logic       byte_valid_out,
  output logic [7:0] byte_out,
  output logic       is_last_byte_out,
  output logic       epb_inserted_out,
  output logic       xfer
);

  logic       out_valid_q, out_last_q, out_epb_q;
  logic [7:0] out_byte_q;
  logic       hold_valid_q, hold_last_q;
  logic [7:0] hold_byte_q;
  logic [1:0] zero_run_q;

  logic       slot_free, cand_valid, cand_last, insert;
  logic [7:0] cand;

  always_comb begin
    xfer       = ena & out_valid_q & byte_ready_in;
    slot_free  = ~out_valid_q | xfer;
    can_take   = slot_free & ~hold_valid_q;
    cand_valid = hold_valid_q | in_valid;
    cand       = hold_valid_q ? hold_byte_q : in_byte;
    cand_last  = hold_valid_q ? hold_last_q : in_last;
    // A held byte directly follows its 0x03, so it is never a candidate for insertion.
    insert     = EPB_EN & ~hold_valid_q & (zero_run_q == 2'd2) & (cand <= EPB_BYTE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_byte_q   <= 8'h00;
      out_last_q   <= 1'b0;
      out_epb_q    <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_byte_q  <= 8'h00;
      hold_last_q  <= 1'b0;
      zero_run_q   <= 2'd0;
    end else if (ena) begin
      if (slot_free) begin
        out_valid_q <= cand_valid;
        if (cand_valid) begin
          if (insert) begin
            out_byte_q   <= EPB_BYTE;
            out_epb_q    <= 1'b1;
            out_last_q   <= 1'b0;
            hold_valid_q <= 1'b1;
            hold_byte_q  <= cand;
            hold_last_q  <= cand_last;
            zero_run_q   <= 2'd0;
          end else begin
            out_byte_q   <= cand;
            out_epb_q    <= 1'b0;
            out_last_q   <= cand_last;
            hold_valid_q <= 1'b0;
            if (cand != 8'h00)           zero_run_q <= 2'd0;
            else if (zero_run_q != 2'd2) zero_run_q <= zero_run_q + 2'd1;
          end
        end
      end
      if (clear_run) zero_run_q <= 2'd0;
    end
  end

  assign byte_valid_out   = out_valid_q;
  assign byte_out         = out_byte_q;
  assign is_last_byte_out = out_last_q;
  assign epb_inserted_out = out_epb_q;

endmodule

// File: rtl/rbsp_bit_writer.sv
// RBSP bit writer: packs MSB-first variable-length fields into bytes, appends
// rbsp_trailing_bits on request and emits a byte stream with emulation prevention.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   ena                        global enable, 0 freezes all state and handshakes
//   bits_valid_in/bits_in/
//   bits_len_in/bits_ready_out field input (right-justified, length 0..32)
//   flush_trailing_in          append stop bit + alignment and close the RBSP
//   byte_valid_out/byte_out/
//   byte_ready_in              output byte stream
//   is_last_byte_out           final byte of the RBSP
//   epb_inserted_out           current byte is an inserted 0x03
//   flush_done_out             one-cycle pulse after the final byte transfers
//   rbsp_bit_counter           bits written since the last flush_done_out
module rbsp_bit_writer
  import rbsp_bit_writer_pkg::*;
#(
  parameter int unsigned ACC_W  = 64,
  parameter bit          EPB_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        bits_valid_in,
  input  logic [31:0] bits_in,
  input  logic [5:0]  bits_len_in,
  output logic        bits_ready_out,
  input  logic        flush_trailing_in,
  output logic        byte_valid_out,
  output logic [7:0]  byte_out,
  input  logic        byte_ready_in,
  output logic        is_last_byte_out,
  output logic        epb_inserted_out,
  output logic        flush_done_out,
  output logic [31:0] rbsp_bit_counter
);

  localparam int unsigned CntW = $clog2(ACC_W + 1);

  state_e            state_q;
  logic [ACC_W-1:0]  acc_q, acc_d, acc_sh, field_pos, stop_pos;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_sh;
  logic [31:0]       counter_q, counter_d, mask;
  logic [5:0]        len;
  logic [3:0]        pad;
  logic              flush_done_q;
  logic              field_acc, flush_acc, extract, extract_last;
  logic              epb_can_take, xfer, last_xfer;

  assign bits_ready_out = (state_q == S_RUN) & (cnt_q <= CntW'(ACC_W - MAX_FIELD_LEN));

  always_comb begin
    field_acc    = ena & bits_valid_in & bits_ready_out;
    flush_acc    = ena & flush_trailing_in & bits_ready_out & ~bits_valid_in;
    extract      = ena & (cnt_q >= CntW'(8)) & epb_can_take;
    extract_last = (state_q == S_FLUSH) & (cnt_q == CntW'(8));
    len          = (bits_len_in > 6'd32) ? 6'd32 : bits_len_in;
    mask         = (len == 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << len) - 32'd1);
    // Extraction happens first, so appended bits land behind the shifted contents.
    acc_sh       = extract ? (acc_q << 8) : acc_q;
    cnt_sh       = extract ? (cnt_q - CntW'(8)) : cnt_q;
    pad          = 4'd8 - {1'b0, cnt_q[2:0]};
    field_pos    = ({bits_in & mask, {(ACC_W - 32){1'b0}}} << (6'd32 - len)) >> cnt_sh;
    stop_pos     = {1'b1, {(ACC_W - 1){1'b0}}} >> cnt_sh;
    acc_d        = acc_sh;
    cnt_d        = cnt_sh;
    counter_d    = counter_q;
    if (field_acc) begin
      acc_d     = acc_sh | field_pos;
      cnt_d     = cnt_sh + CntW'(len);
      counter_d = counter_q + 32'(len);
    end else if (flush_acc) begin
      // Bits below cnt are always zero, so only the stop bit needs setting.
      acc_d     = acc_sh | stop_pos;
      cnt_d     = cnt_sh + CntW'(pad);
      counter_d = counter_q + 32'(pad);
    end
  end

  assign last_xfer = xfer & is_last_byte_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RUN;
      acc_q        <= '0;
      cnt_q        <= '0;
      counter_q    <= 32'd0;
      flush_done_q <= 1'b0;
    end else if (ena) begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      counter_q    <= last_xfer ? 32'd0 : counter_d;
      flush_done_q <= last_xfer;
      unique case (state_q)
        S_RUN:   if (flush_acc) state_q <= S_FLUSH;
        S_FLUSH: if (last_xfer) state_q <= S_DONE;
        S_DONE:  state_q <= S_RUN;
        default: state_q <= S_RUN;
      endcase
    end
  end

  assign flush_done_out   = flush_done_q;
  assign rbsp_bit_counter = counter_q;

  rbsp_epb_inserter #(
    .EPB_EN(EPB_EN)
  ) u_epb (
    .clk              (clk),
    .rst_n            (rst_n),
    .ena              (ena),
    .in_valid         (extract),
    .in_byte          (acc_q[ACC_W-1 -: 8]),
    .in_last          (extract_last),
    .clear_run        (last_xfer),
    .can_take         (epb_can_take),
    .byte_ready_in    (byte_ready_in),
    .byte_valid_out   (byte_valid_out),
    .byte_out         (byte_out),
    .is_last_byte_out (is_last_byte_out),
    .epb_inserted_out (epb_inserted_out),
    .xfer             (xfer)
  );

endmodule

// File: tb/tb_rbsp_bit_writer.sv
// Directed self-checking bench for rbsp_bit_writer.
module tb_rbsp_bit_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic        bits_valid_in = 1'b0;
  logic [31:0] bits_in = 32'd0;
  logic [5:0]  bits_len_in = 6'd0;
  logic        bits_ready_out;
  logic        flush_trailing_in = 1'b0;
  logic        byte_valid_out;
  logic [7:0]  byte_out;
  logic        byte_ready_in = 1'b1;
  logic        is_last_byte_out;
  logic        epb_inserted_out;
  logic        flush_done_out;
  logic [31:0] rbsp_bit_counter;

  int checks = 0;
  int errors = 0;

  logic [7:0] q_byte[$];
  bit         q_epb[$];
  bit         q_last[$];

  rbsp_bit_writer #(
    .ACC_W (64),
    .EPB_EN(1'b1)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ena              (ena),
    .bits_valid_in    (bits_valid_in),
    .bits_in          (bits_in),
    .bits_len_in      (bits_len_in),
    .bits_ready_out   (bits_ready_out),
    .flush_trailing_in(flush_trailing_in),
    .byte_valid_out   (byte_valid_out),
    .byte_out         (byte_out),
    .byte_ready_in    (byte_ready_in),
    .is_last_byte_out (is_last_byte_out),
    .epb_inserted_out (epb_inserted_out),
    .flush_done_out   (flush_done_out),
    .rbsp_bit_counter (rbsp_bit_counter)
  );

  always #5 clk = ~clk;

  // Inputs change just after posedge, so a negedge sample predicts the next transfer.
  always @(negedge clk) begin
    if (rst_n && ena && byte_valid_out && byte_ready_in) begin
      q_byte.push_back(byte_out);
      q_epb.push_back(epb_inserted_out);
      q_last.push_back(is_last_byte_out);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] d, input logic [5:0] l);
    int n = 0;
    bits_in = d; bits_len_in = l; bits_valid_in = 1'b1;
    do begin @(negedge clk); n++; end while (!bits_ready_out && n < 500);
    @(posedge clk); #1;
    bits_valid_in = 1'b0;
    if (n >= 500) chk("put_timeout", 32'(n), 32'd0);
  endtask

  task automatic flush();
    int n = 0;
    flush_trailing_in = 1'b1;
    do begin @(negedge clk); n++; end while (!bits_ready_out && n < 500);
    @(posedge clk); #1;
    flush_trailing_in = 1'b0;
    if (n >= 500) chk("flush_timeout", 32'(n), 32'd0);
  endtask

  task automatic wait_bytes(input int k);
    int n = 0;
    while (q_byte.size() < k && n < 2000) begin @(posedge clk); n++; end
    idle(4);
    chk("byte_count", 32'(q_byte.size()), 32'(k));
  endtask

  task automatic clear_q();
    q_byte.delete(); q_epb.delete(); q_last.delete();
  endtask

  initial begin
    logic [7:0] exp_b [$];
    logic [7:0] b8;
    logic [31:0] f;
    int n;

    // Reset values
    #12;
    chk("rst_ready", 32'(bits_ready_out), 32'd1);
    chk("rst_bvalid", 32'(byte_valid_out), 32'd0);
    chk("rst_byte", 32'(byte_out), 32'd0);
    chk("rst_flags", {29'd0, is_last_byte_out, epb_inserted_out, flush_done_out}, 32'd0);
    chk("rst_counter", rbsp_bit_counter, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    idle(2);

    // Two fields forming 0xA6, with one-edge extraction latency
    put(32'h5, 6'd3);
    put(32'h06, 6'd5);
    chk("lat_before", 32'(byte_valid_out), 32'd0);
    idle(1);
    chk("lat_valid", 32'(byte_valid_out), 32'd1);
    chk("lat_byte", 32'(byte_out), 32'hA6);
    wait_bytes(1);
    chk("a6_byte", 32'(q_byte[0]), 32'hA6);
    chk("a6_flags", {30'd0, q_epb[0], q_last[0]}, 32'd0);
    chk("a6_counter", rbsp_bit_counter, 32'd8);
    clear_q();

    // ena=0 freezes: a presented field is not accepted
    ena = 1'b0; bits_in = 32'hFF; bits_len_in = 6'd8; bits_valid_in = 1'b1;
    idle(3);
    bits_valid_in = 1'b0; ena = 1'b1;
    idle(3);
    chk("ena_counter", rbsp_bit_counter, 32'd8);
    chk("ena_nobyte", 32'(q_byte.size()), 32'd0);

    // 00 00 01 -> 00 00 03 01
    put(32'h0, 6'd16);
    put(32'h01, 6'd8);
    wait_bytes(4);
    chk("epb1_b2", 32'(q_byte[2]), 32'h03);
    chk("epb1_f2", 32'(q_epb[2]), 32'd1);
    chk("epb1_b3", 32'(q_byte[3]), 32'h01);
    chk("epb1_f3", 32'(q_epb[3]), 32'd0);
    chk("epb1_b01", {q_byte[0], q_byte[1]}, 32'h0000);
    clear_q();

    // 00 00 04 passes unchanged
    put(32'h0, 6'd16);
    put(32'h04, 6'd8);
    wait_bytes(3);
    chk("noepb_b2", 32'(q_byte[2]), 32'h04);
    chk("noepb_f", {29'd0, q_epb[0], q_epb[1], q_epb[2]}, 32'd0);
    clear_q();

    // 32 zero bits, then 0x02 shows the zero run carrying across fields
    put(32'h0, 6'd32);
    put(32'h02, 6'd8);
    wait_bytes(7);
    exp_b = '{8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h03, 8'h02};
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("zero32_b%0d", i), 32'(q_byte[i]), 32'(exp_b[i]));
      chk($sformatf("zero32_e%0d", i), 32'(q_epb[i]), (i == 2 || i == 5) ? 32'd1 : 32'd0);
    end
    clear_q();

    // 10011 + flush -> 0x9C, last byte, flush_done pulse, counter reset
    put(32'h13, 6'd5);
    flush();
    chk("fl_counter", rbsp_bit_counter, 32'd104);
    chk("fl_ready", 32'(bits_ready_out), 32'd0);
    n = 0;
    while (!(byte_valid_out && is_last_byte_out) && n < 100) begin idle(1); n++; end
    chk("fl_byte", 32'(byte_out), 32'h9C);
    chk("fl_done_early", 32'(flush_done_out), 32'd0);
    idle(1);
    chk("fl_done", 32'(flush_done_out), 32'd1);
    chk("fl_cnt0", rbsp_bit_counter, 32'd0);
    idle(1);
    chk("fl_done_off", 32'(flush_done_out), 32'd0);
    chk("fl_ready_back", 32'(bits_ready_out), 32'd1);
    chk("fl_nbytes", 32'(q_byte.size()), 32'd1);
    chk("fl_last", 32'(q_last[0]), 32'd1);
    clear_q();

    // Backpressure: ready drops, byte held, nothing lost
    byte_ready_in = 1'b0;
    for (int i = 0; i < 2; i++) put(32'h11223344 + 32'(i) * 32'h01010101, 6'd32);
    idle(3);
    chk("bp_ready", 32'(bits_ready_out), 32'd0);
    chk("bp_byte", 32'(byte_out), 32'h11);
    idle(5);
    chk("bp_stable", {23'd0, byte_valid_out, byte_out}, 32'h111);
    chk("bp_none", 32'(q_byte.size()), 32'd0);
    byte_ready_in = 1'b1;
    for (int i = 2; i < 40; i++) put(32'h11223344 + 32'(i) * 32'h01010101, 6'd32);
    wait_bytes(160);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      f = 32'h11223344 + 32'(i) * 32'h01010101;
      for (int j = 0; j < 4; j++) begin
        b8 = f[31 - 8 * j -: 8];
        if (q_byte.size() > 4 * i + j && q_byte[4 * i + j] !== b8) n++;
      end
    end
    chk("bp_order_errs", 32'(n), 32'd0);
    chk("bp_first", 32'(q_byte[0]), 32'h11);
    chk("bp_final", 32'(q_byte[159]), 32'h6B);
    clear_q();

    // Reset during S_FLUSH with a pending byte
    byte_ready_in = 1'b0;
    put(32'hAB, 6'd8);
    flush();
    idle(2);
    chk("mr_valid", 32'(byte_valid_out), 32'd1);
    chk("mr_ready", 32'(bits_ready_out), 32'd0);
    rst_n = 1'b0;
    #2;
    chk("mr_bvalid", 32'(byte_valid_out), 32'd0);
    chk("mr_byte", 32'(byte_out), 32'd0);
    chk("mr_flags", {29'd0, is_last_byte_out, epb_inserted_out, flush_done_out}, 32'd0);
    chk("mr_ready1", 32'(bits_ready_out), 32'd1);
    chk("mr_counter", rbsp_bit_counter, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    byte_ready_in = 1'b1;
    idle(1);
    put(32'h5A, 6'd8);
    wait_bytes(1);
    chk("mr_clean", 32'(q_byte[0]), 32'h5A);
    chk("mr_counter8", rbsp_bit_counter, 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
